// File: rtl/param_stack_pkg.sv
`default_nettype none
// ============================================================
// param_stack_pkg : operation encoding and decode for param_stack
// Rev 1.0
// ============================================================
package param_stack_pkg;

   typedef enum logic [2:0] {
      OP_IDLE      = 3'd0,
      OP_SETSP     = 3'd1,
      OP_PUSH      = 3'd2,
      OP_PUSH_FULL = 3'd3,
      OP_POP       = 3'd4,
      OP_POP_EMPTY = 3'd5,
      OP_REPLACE   = 3'd6
   } stack_op_e;

   // SP load dominates push/pop; push+pop on an empty stack degrades to a plain push.
   function automatic stack_op_e decode_op(input logic set_sp, input logic push,
                                           input logic pop, input logic empty,
                                           input logic full);
      stack_op_e op;
      op = OP_IDLE;
      if (set_sp)
         op = OP_SETSP;
      else if (push && pop)
         op = empty ? OP_PUSH : OP_REPLACE;
      else if (push)
         op = full ? OP_PUSH_FULL : OP_PUSH;
      else if (pop)
         op = empty ? OP_POP_EMPTY : OP_POP;
      return op;
   endfunction

endpackage
`default_nettype wire

// File: rtl/param_stack_mem.sv
`default_nettype none
// ============================================================
// stack_mem : entry storage, one synchronous write port and one
// asynchronous read port. Rev 1.0
// ============================================================
module stack_mem #(
   parameter  int DATA_WIDTH = 16,
   parameter  int DEPTH      = 64,
   localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/param_stack.sv
`default_nettype none
// ============================================================
// param_stack : LIFO with registered top-of-stack, replace,
// saturating SP load and sticky error flags. Rev 1.0
// ============================================================
module param_stack
   import param_stack_pkg::*;
#(
   parameter  int DATA_WIDTH = 16,
   parameter  int DEPTH      = 64,
   localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  iPush,
   input  logic                  iPop,
   input  logic                  iSetSP,
   input  logic [ADDR_WIDTH:0]   iSPIn,
   input  logic                  iClearErr,
   input  logic [DATA_WIDTH-1:0] iDataIn,
   output logic [DATA_WIDTH-1:0] oDataOut,
   output logic [ADDR_WIDTH:0]   oCount,
   output logic                  oEmpty,
   output logic                  oFull,
   output logic                  oOverflow,
   output logic                  oUnderflow
);

   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

   logic [ADDR_WIDTH:0]   count;
   logic [DATA_WIDTH-1:0] top;
   logic                  ovf, unf;

   stack_op_e             op;
   logic [ADDR_WIDTH:0]   sp_sat, sp_m1, cnt_m1, cnt_m2;
   logic [ADDR_WIDTH-1:0] raddr, waddr;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  we, ovf_set, unf_set;

   always_comb begin
      op      = decode_op(iSetSP, iPush, iPop, (count == '0), (count == DEPTH_C));
      sp_sat  = (iSPIn > DEPTH_C) ? DEPTH_C : iSPIn;
      sp_m1   = sp_sat - 1'b1;
      cnt_m1  = count - 1'b1;
      cnt_m2  = count - 2'd2;
      raddr   = '0;
      waddr   = count[ADDR_WIDTH-1:0];
      we      = 1'b0;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      case (op)
         OP_SETSP: begin
            raddr   = sp_m1[ADDR_WIDTH-1:0];
            ovf_set = (iSPIn > DEPTH_C);
         end
         OP_PUSH:      we = 1'b1;
         OP_REPLACE: begin
            we    = 1'b1;
            waddr = cnt_m1[ADDR_WIDTH-1:0];
         end
         OP_POP:       raddr = cnt_m2[ADDR_WIDTH-1:0];
         OP_PUSH_FULL: ovf_set = 1'b1;
         OP_POP_EMPTY: unf_set = 1'b1;
         default: ;
      endcase
   end

   stack_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_mem (
      .clk   (Clock),
      .we    (we && Reset),
      .waddr (waddr),
      .wdata (iDataIn),
      .raddr (raddr),
      .rdata (rdata)
   );

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         count <= '0;
         top   <= '0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
      end else begin
         case (op)
            OP_SETSP: begin
               count <= sp_sat;
               top   <= (sp_sat == '0) ? '0 : rdata;
            end
            OP_PUSH: begin
               count <= count + 1'b1;
               top   <= iDataIn;
            end
            OP_REPLACE: top <= iDataIn;
            OP_POP: begin
               count <= cnt_m1;
               top   <= (count == 1) ? '0 : rdata;
            end
            default: ;
         endcase
         // A fresh error event outranks a coincident clear.
         ovf <= ovf_set | (ovf & ~iClearErr);
         unf <= unf_set | (unf & ~iClearErr);
      end
   end

   assign oDataOut   = top;
   assign oCount     = count;
   assign oEmpty     = (count == '0);
   assign oFull      = (count == DEPTH_C);
   assign oOverflow  = ovf;
   assign oUnderflow = unf;

endmodule
`default_nettype wire
